// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters and the memory arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface mem_bus_arbiter_if;
  logic [1:0]  req;
  logic [19:0] addr0;
  logic [19:0] addr1;
  logic        we0;
  logic        we1;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [19:0] bus_addr;
  logic        bus_we;
  logic        cs_rom;
  logic        cs_vr;
  logic [3:0]  cs_ram;
  logic        busy;

  modport master (
    output req, addr0, addr1, we0, we1,
    input  gnt, ack, bus_addr, bus_we, cs_rom, cs_vr, cs_ram, busy
  );

  modport slave (
    input  req, addr0, addr1, we0, we1,
    output gnt, ack, bus_addr, bus_we, cs_rom, cs_vr, cs_ram, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the 1 MiB space.
// Latches the winner's address, drives the region chip select and holds it
// for the region's wait states, then pulses ack for one cycle.
module mem_bus_arbiter #(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 1,
  parameter int VR_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_bus_arbiter_if.slave      bus
);

  localparam int MAX_RV = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
  localparam int MAX_W  = (MAX_RV > VR_WAIT) ? MAX_RV : VR_WAIT;
  localparam int CNT_W  = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [19:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic               win_sel;
  logic [1:0]         gnt_oh;

  function automatic logic is_rom(input logic [19:0] a);
    return (a < 20'h04000);
  endfunction

  function automatic logic is_vr(input logic [19:0] a);
    return (a >= 20'hF0000);
  endfunction

  function automatic logic [CNT_W-1:0] wait_for(input logic [19:0] a);
    if (is_rom(a))     return CNT_W'(ROM_WAIT);
    else if (is_vr(a)) return CNT_W'(VR_WAIT);
    else               return CNT_W'(RAM_WAIT);
  endfunction

  // State register: control state is reset, an in-flight access is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  // Latched access data; outputs are gated by state so no reset is needed.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    we_q   <= we_d;
  end

  // Next-state logic: arbitrate in IDLE, count down wait states in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    win_sel = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // With both pending, the master not served last wins.
          if (bus.req == 2'b01)      win_sel = 1'b0;
          else if (bus.req == 2'b10) win_sel = 1'b1;
          else                       win_sel = ~last_q;
          addr_d  = win_sel ? bus.addr1 : bus.addr0;
          we_d    = win_sel ? bus.we1   : bus.we0;
          cnt_d   = wait_for(win_sel ? bus.addr1 : bus.addr0);
          win_d   = win_sel;
          last_d  = win_sel;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and latched address only.
  always_comb begin
    gnt_oh       = 2'b00;
    bus.gnt      = 2'b00;
    bus.ack      = 2'b00;
    bus.bus_addr = 20'h00000;
    bus.bus_we   = 1'b0;
    bus.cs_rom   = 1'b0;
    bus.cs_vr    = 1'b0;
    bus.cs_ram   = 4'b0000;
    bus.busy     = 1'b0;
    if (state_q == ACCESS) begin
      gnt_oh       = win_q ? 2'b10 : 2'b01;
      bus.gnt      = gnt_oh;
      bus.ack      = (cnt_q == '0) ? gnt_oh : 2'b00;
      bus.bus_addr = addr_q;
      bus.bus_we   = we_q;
      bus.busy     = 1'b1;
      if (is_rom(addr_q))     bus.cs_rom = 1'b1;
      else if (is_vr(addr_q)) bus.cs_vr  = 1'b1;
      else                    bus.cs_ram = 4'b0001 << addr_q[19:18];
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default-parameter instance plus a
// ROM_WAIT=0 / VR_WAIT=3 instance, checked with immediate assertions.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_bus_arbiter_if b ();
  mem_bus_arbiter_if bp ();

  mem_bus_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  mem_bus_arbiter #(.ROM_WAIT(0), .RAM_WAIT(1), .VR_WAIT(3)) u_par (
    .clk (clk),
    .rst (rst),
    .bus (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gnt, ack, bus_addr, bus_we, cs_rom, cs_vr, cs_ram, busy}
  function automatic logic [31:0] pk(input logic [1:0] g, input logic [1:0] a,
                                     input logic [19:0] ad, input logic w,
                                     input logic rom, input logic vr,
                                     input logic [3:0] ram, input logic bsy);
    return {g, a, ad, w, rom, vr, ram, bsy};
  endfunction

  function automatic logic [31:0] obs(input int d);
    if (d == 0) return pk(b.gnt, b.ack, b.bus_addr, b.bus_we, b.cs_rom, b.cs_vr, b.cs_ram, b.busy);
    else        return pk(bp.gnt, bp.ack, bp.bus_addr, bp.bus_we, bp.cs_rom, bp.cs_vr, bp.cs_ram, bp.busy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int d, input string tag, input logic [31:0] exp);
    logic [31:0] o;
    o = obs(d);
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic set_req(input int d, input logic [1:0] r);
    if (d == 0) b.req = r;
    else        bp.req = r;
  endtask

  task automatic set_m(input int d, input logic m, input logic [19:0] a, input logic w);
    if (d == 0) begin
      if (m) begin b.addr1 = a; b.we1 = w; end
      else   begin b.addr0 = a; b.we0 = w; end
    end else begin
      if (m) begin bp.addr1 = a; bp.we1 = w; end
      else   begin bp.addr0 = a; bp.we0 = w; end
    end
  endtask

  // One single-master access of wt wait states, then the following IDLE cycle.
  task automatic run_access(input int d, input string tag, input logic m,
                            input logic [19:0] a, input logic w, input int wt,
                            input logic rom, input logic vr, input logic [3:0] ram);
    logic [1:0] g;
    g = m ? 2'b10 : 2'b01;
    set_m(d, m, a, w);
    set_req(d, g);
    for (int i = 0; i <= wt; i++) begin
      tick();
      chk(d, $sformatf("%s_c%0d", tag, i), pk(g, (i == wt) ? g : 2'b00, a, w, rom, vr, ram, 1'b1));
      if (i == wt) set_req(d, 2'b00);
    end
    tick();
    chk(d, {tag, "_idle"}, 32'h0);
  endtask

  initial begin
    logic        m;
    logic [1:0]  g;
    logic [19:0] ea;
    logic [3:0]  er;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b.req = 2'b00;  b.addr0 = '0;  b.addr1 = '0;  b.we0 = 1'b0;  b.we1 = 1'b0;
    bp.req = 2'b00; bp.addr0 = '0; bp.addr1 = '0; bp.we0 = 1'b0; bp.we1 = 1'b0;

    // Reset state
    tick();
    tick();
    chk(0, "reset_state", 32'h0);
    chk(1, "reset_state_par", 32'h0);
    rst = 1'b0;

    // First access after reset: ROM, 3 cycles
    run_access(0, "rom_first", 1'b0, 20'h00100, 1'b0, 2, 1'b1, 1'b0, 4'b0000);

    // Map boundaries
    run_access(0, "rom_top",   1'b0, 20'h03FFF, 1'b0, 2, 1'b1, 1'b0, 4'b0000);
    run_access(0, "ram0_base", 1'b0, 20'h04000, 1'b1, 1, 1'b0, 1'b0, 4'b0001);
    run_access(0, "ram3_base", 1'b0, 20'hC0000, 1'b0, 1, 1'b0, 1'b0, 4'b1000);
    run_access(0, "ram3_top",  1'b0, 20'hEFFFF, 1'b0, 1, 1'b0, 1'b0, 4'b1000);
    run_access(0, "vram_base", 1'b0, 20'hF0000, 1'b0, 0, 1'b0, 1'b1, 4'b0000);

    // Contention after a fresh reset: master 0 first, then alternating
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(0, 1'b0, 20'h10000, 1'b0);
    set_m(0, 1'b1, 20'h90000, 1'b1);
    set_req(0, 2'b11);
    for (int k = 0; k < 4; k++) begin
      m  = (k % 2 == 1);
      g  = m ? 2'b10 : 2'b01;
      ea = m ? 20'h90000 : 20'h10000;
      er = m ? 4'b0100 : 4'b0001;
      tick();
      chk(0, $sformatf("contend%0d_c0", k), pk(g, 2'b00, ea, m, 1'b0, 1'b0, er, 1'b1));
      tick();
      chk(0, $sformatf("contend%0d_c1", k), pk(g, g, ea, m, 1'b0, 1'b0, er, 1'b1));
      if (k == 3) set_req(0, 2'b00);
      tick();
      chk(0, $sformatf("contend%0d_idle", k), 32'h0);
    end

    // Input stability: inputs change mid-access
    set_m(0, 1'b1, 20'h50000, 1'b1);
    set_req(0, 2'b10);
    tick();
    chk(0, "stable_c0", pk(2'b10, 2'b00, 20'h50000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1));
    set_m(0, 1'b1, 20'hF0000, 1'b0);
    set_req(0, 2'b00);
    tick();
    chk(0, "stable_c1", pk(2'b10, 2'b10, 20'h50000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1));
    tick();
    chk(0, "stable_idle", 32'h0);

    // Reset in the 2nd cycle of a ROM access
    set_m(0, 1'b0, 20'h00200, 1'b0);
    set_req(0, 2'b01);
    tick();
    chk(0, "abort_c0", pk(2'b01, 2'b00, 20'h00200, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1));
    tick();
    chk(0, "abort_c1", pk(2'b01, 2'b00, 20'h00200, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1));
    rst = 1'b1;
    set_req(0, 2'b00);
    tick();
    chk(0, "abort_reset", 32'h0);
    rst = 1'b0;
    set_m(0, 1'b0, 20'h00300, 1'b0);
    set_m(0, 1'b1, 20'h60000, 1'b0);
    set_req(0, 2'b11);
    tick();
    chk(0, "post_reset_c0", pk(2'b01, 2'b00, 20'h00300, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1));
    tick();
    chk(0, "post_reset_c1", pk(2'b01, 2'b00, 20'h00300, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1));
    tick();
    chk(0, "post_reset_c2", pk(2'b01, 2'b01, 20'h00300, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1));
    set_req(0, 2'b00);
    tick();
    chk(0, "post_reset_idle", 32'h0);

    // Parameter override instance: ROM 1 cycle, VRAM 4 cycles
    run_access(1, "par_rom",  1'b0, 20'h00100, 1'b0, 0, 1'b1, 1'b0, 4'b0000);
    run_access(1, "par_vram", 1'b1, 20'hF8000, 1'b1, 3, 1'b0, 1'b1, 4'b0000);
    run_access(1, "par_ram",  1'b0, 20'h84000, 1'b0, 1, 1'b0, 1'b0, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
